// File: rtl/noc_eject_sink.sv
// Ejection receiver on a mesh router's local output: registers each flit, checks destination
// and per-source sequence continuity, buffers matches in a FWFT FIFO and keeps saturating stats.
module noc_eject_sink #(
    parameter int DATAWID  = 32,
    parameter int NODE_ROW = 0,
    parameter int NODE_COL = 0,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATAWID-1:0]         flit_in,
    input  logic                       stat_clr,
    output logic [DATAWID-1:0]         out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [CNT_W-1:0]           rx_cnt,
    output logic [CNT_W-1:0]           misroute_cnt,
    output logic [CNT_W-1:0]           seq_err_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [2:0]                 last_tag
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [3:0]     MY_NODE  = 4'((NODE_ROW % 4) * 4 + (NODE_COL % 4));
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0]  ONE_PTR  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATAWID-1:0] r_in_q;
    logic [DATAWID-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [15:0]        r_seen;
    logic [5:0]         r_exp_seq [16];
    logic [CNT_W-1:0]   r_rx_cnt;
    logic [CNT_W-1:0]   r_misroute_cnt;
    logic [CNT_W-1:0]   r_seq_err_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [2:0]         r_last_tag;

    logic       w_valid;
    logic       w_match;
    logic       w_accept;
    logic       w_misroute;
    logic       w_seq_err;
    logic [3:0] w_src;
    logic [5:0] w_seq;
    logic       w_pop;
    logic       w_full;
    logic       w_push;
    logic       w_drop;

    assign w_valid    = r_in_q[31];
    assign w_src      = r_in_q[30:27];
    assign w_seq      = r_in_q[22:17];
    assign w_match    = (r_in_q[26:23] == MY_NODE);
    assign w_accept   = w_valid && w_match;
    assign w_misroute = w_valid && !w_match;
    assign w_seq_err  = w_accept && r_seen[w_src] && (w_seq != r_exp_seq[w_src]);

    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign w_full     = (r_count == FULL_CNT);
    // Room is judged after this cycle's pop, so a full FIFO can pop and push together.
    assign w_push     = w_accept && (!w_full || w_pop);
    assign w_drop     = w_accept && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_q   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_in_q <= flit_in;
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_in_q;
                r_wr_ptr        <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + ONE_PTR;
            if (w_push && !w_pop)      r_count <= r_count + ONE_CNT;
            else if (w_pop && !w_push) r_count <= r_count - ONE_CNT;
        end
    end

    // Sequence table is updated for every matching flit, including dropped ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seen <= '0;
            for (int i = 0; i < 16; i++) r_exp_seq[i] <= '0;
        end else if (w_accept) begin
            r_seen[w_src]    <= 1'b1;
            r_exp_seq[w_src] <= w_seq + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_cnt       <= '0;
            r_misroute_cnt <= '0;
            r_seq_err_cnt  <= '0;
            r_drop_cnt     <= '0;
            r_last_tag     <= '0;
        end else if (stat_clr) begin
            r_rx_cnt       <= '0;
            r_misroute_cnt <= '0;
            r_seq_err_cnt  <= '0;
            r_drop_cnt     <= '0;
            r_last_tag     <= '0;
        end else begin
            if (w_push) begin
                r_last_tag <= r_in_q[16:14];
                if (r_rx_cnt != CNT_MAX) r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (w_misroute && r_misroute_cnt != CNT_MAX) r_misroute_cnt <= r_misroute_cnt + 1'b1;
            if (w_seq_err && r_seq_err_cnt != CNT_MAX)   r_seq_err_cnt  <= r_seq_err_cnt + 1'b1;
            if (w_drop && r_drop_cnt != CNT_MAX)         r_drop_cnt     <= r_drop_cnt + 1'b1;
        end
    end

    assign out_data     = r_mem[r_rd_ptr];
    assign fill_level   = r_count;
    assign rx_cnt       = r_rx_cnt;
    assign misroute_cnt = r_misroute_cnt;
    assign seq_err_cnt  = r_seq_err_cnt;
    assign drop_cnt     = r_drop_cnt;
    assign last_tag     = r_last_tag;

endmodule

// File: tb/tb_noc_eject_sink.sv
// Directed bench for noc_eject_sink at node (1,1), DEPTH=4, with hand-computed expectations.
module tb_noc_eject_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] flit_in;
    logic        stat_clr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill_level;
    logic [15:0] rx_cnt;
    logic [15:0] misroute_cnt;
    logic [15:0] seq_err_cnt;
    logic [15:0] drop_cnt;
    logic [2:0]  last_tag;

    int checks   = 0;
    int failures = 0;

    noc_eject_sink #(
        .DATAWID (32),
        .NODE_ROW(1),
        .NODE_COL(1),
        .DEPTH   (4),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flit_in     (flit_in),
        .stat_clr    (stat_clr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .rx_cnt      (rx_cnt),
        .misroute_cnt(misroute_cnt),
        .seq_err_cnt (seq_err_cnt),
        .drop_cnt    (drop_cnt),
        .last_tag    (last_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] src, input logic [3:0] dst,
                                       input logic [5:0] seq, input logic [2:0] tag,
                                       input logic [13:0] pay);
        return {1'b1, src, dst, seq, tag, pay};
    endfunction

    localparam logic [3:0] ME = 4'b0101;
    logic [31:0] ovf [6];

    initial begin
        reset     = 1'b0;
        flit_in   = '0;
        stat_clr  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fill",  32'(fill_level), 32'd0);
        chk("rst_rx",    32'(rx_cnt), 32'd0);
        chk("rst_tag",   32'(last_tag), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single flit: out_valid must rise exactly two edges after it is driven.
        flit_in = 32'h8281_5234;
        tick();
        flit_in = '0;
        chk("single_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  out_data, 32'h8281_5234);
        chk("single_rx",    32'(rx_cnt), 32'd1);
        chk("single_tag",   32'(last_tag), 32'd5);
        chk("single_fill",  32'(fill_level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_drained", 32'(fill_level), 32'd0);

        // Misroute
        flit_in = mk(4'd2, 4'd0, 6'd0, 3'd1, 14'h11);
        tick();
        flit_in = '0;
        tick();
        tick();
        chk("mis_cnt",   32'(misroute_cnt), 32'd1);
        chk("mis_valid", 32'(out_valid), 32'd0);
        chk("mis_rx",    32'(rx_cnt), 32'd1);

        // Sequence: src 3 sends 0,1,3 then 4
        out_ready = 1'b1;
        flit_in = mk(4'd3, ME, 6'd0, 3'd0, 14'h30);
        tick();
        flit_in = mk(4'd3, ME, 6'd1, 3'd0, 14'h31);
        tick();
        flit_in = mk(4'd3, ME, 6'd3, 3'd0, 14'h33);
        tick();
        flit_in = '0;
        tick();
        tick();
        chk("seq_err_gap", 32'(seq_err_cnt), 32'd1);
        chk("seq_rx3",     32'(rx_cnt), 32'd4);
        flit_in = mk(4'd3, ME, 6'd4, 3'd2, 14'h34);
        tick();
        flit_in = '0;
        tick();
        tick();
        chk("seq_no_err",  32'(seq_err_cnt), 32'd1);
        chk("seq_rx4",     32'(rx_cnt), 32'd5);
        chk("seq_drained", 32'(fill_level), 32'd0);

        // Overflow with out_ready low: six flits, four kept, two dropped
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) ovf[i] = mk(4'd5, ME, 6'(i), 3'd3, 14'(16'h100 + i));
        for (int i = 0; i < 6; i++) begin
            flit_in = ovf[i];
            tick();
        end
        flit_in = '0;
        tick();
        tick();
        chk("ovf_fill", 32'(fill_level), 32'd4);
        chk("ovf_rx",   32'(rx_cnt), 32'd9);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_order%0d", i), out_data, ovf[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_empty", 32'(out_valid), 32'd0);

        // Full with simultaneous pop and push
        for (int i = 0; i < 4; i++) begin
            flit_in = mk(4'd6, ME, 6'(i), 3'd4, 14'(16'h200 + i));
            tick();
        end
        flit_in = '0;
        tick();
        tick();
        chk("full_fill", 32'(fill_level), 32'd4);
        flit_in = mk(4'd6, ME, 6'd4, 3'd4, 14'h204);
        tick();
        out_ready = 1'b1;
        for (int i = 5; i < 10; i++) begin
            flit_in = mk(4'd6, ME, 6'(i), 3'd4, 14'(16'h200 + i));
            tick();
            chk($sformatf("full_pp_fill%0d", i), 32'(fill_level), 32'd4);
        end
        flit_in = '0;
        tick();
        chk("full_pp_last", 32'(fill_level), 32'd4);
        chk("full_pp_drop", 32'(drop_cnt), 32'd2);
        chk("full_pp_rx",   32'(rx_cnt), 32'd19);
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        chk("full_drained", 32'(fill_level), 32'd0);

        // Clear coincident with a push: clear wins, FIFO still takes the flit
        flit_in = mk(4'd7, ME, 6'd0, 3'd3, 14'h70);
        tick();
        flit_in  = '0;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_rx",   32'(rx_cnt), 32'd0);
        chk("clr_tag",  32'(last_tag), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_mis",  32'(misroute_cnt), 32'd0);
        chk("clr_fill", 32'(fill_level), 32'd1);

        // Reset mid-stream: src 3 would expect seq 5, send 10 around the reset
        flit_in = mk(4'd3, ME, 6'd10, 3'd1, 14'h3a);
        tick();
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_fill",  32'(fill_level), 32'd0);
        chk("arst_data",  out_data, 32'd0);
        flit_in = '0;
        tick();
        reset = 1'b1;
        tick();
        flit_in = mk(4'd3, ME, 6'd10, 3'd1, 14'h3a);
        tick();
        flit_in = '0;
        tick();
        chk("post_rst_seq", 32'(seq_err_cnt), 32'd0);
        chk("post_rst_rx",  32'(rx_cnt), 32'd1);
        chk("post_rst_val", 32'(out_valid), 32'd1);
        chk("post_rst_dat", out_data, mk(4'd3, ME, 6'd10, 3'd1, 14'h3a));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
